clint_bram: RTL



---
 rtl/clint_pkg.sv | 27 ++
 rtl/clint_bram.sv | 111 +++++++++++
 2 files changed

// File: rtl/clint_pkg.sv
// Shared CLINT register offsets and a byte-enable merge helper
// used by BRAM-port peripherals (8 byte enables on a 64-bit word).
package clint_pkg;

    localparam logic [15:0] MSIP_OFF     = 16'h0000;
    localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace the bytes of old_w selected by be with those of new_w.
    function automatic logic [63:0] apply_be(
        input logic [63:0] old_w,
        input logic [63:0] new_w,
        input logic [7:0]  be
    );
        logic [63:0] res;
        res = old_w;
        for (int k = 0; k < 8; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_bram.sv
// RISC-V CLINT subset (msip, mtimecmp, mtime) on a BRAM-style port.
// Ports: clk_i/rst_ni, bram_en_i/we_i/addr_i/wrdata_i -> bram_rddata_o
// (1-cycle latency); time_o, timer_irq_o, ipi_o to the core.
module clint_bram
    import clint_pkg::*;
#(
    parameter int unsigned RTC_DIV    = 25,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  bram_en_i,
    input  logic [7:0]            bram_we_i,
    input  logic [ADDR_WIDTH-1:0] bram_addr_i,
    input  logic [63:0]           bram_wrdata_i,
    output logic [63:0]           bram_rddata_o,
    output logic [63:0]           time_o,
    output logic                  timer_irq_o,
    output logic                  ipi_o
);

    localparam logic [15:0] CNT_MAX = 16'(RTC_DIV - 1);

    logic [15:0] cnt_q, cnt_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        irq_q, irq_d;
    logic [63:0] rdata_q, rdata_d;

    logic        tick;
    logic        wr;
    logic [15:0] off;
    logic        sel_msip, sel_cmp, sel_time;
    logic [63:0] rd_val;
    logic        unused_addr;

    // Byte lane bits of the address carry no register selection.
    assign unused_addr = ^bram_addr_i[2:0];

    assign off      = 16'({bram_addr_i[ADDR_WIDTH-1:3], 3'b000});
    assign sel_msip = (off == MSIP_OFF);
    assign sel_cmp  = (off == MTIMECMP_OFF);
    assign sel_time = (off == MTIME_OFF);
    assign wr       = bram_en_i & (|bram_we_i);
    assign tick     = (cnt_q == CNT_MAX);

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            sel_msip: rd_val = {63'b0, msip_q};
            sel_cmp:  rd_val = mtimecmp_q;
            sel_time: rd_val = mtime_q;
            default:  rd_val = '0;
        endcase
    end

    always_comb begin
        cnt_d      = tick ? 16'd0 : cnt_q + 16'd1;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        rdata_d    = rdata_q;

        if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        // A software write to mtime wins over the tick increment.
        if (wr && sel_time) begin
            mtime_d = apply_be(mtime_q, bram_wrdata_i, bram_we_i);
        end
        if (wr && sel_cmp) begin
            mtimecmp_d = apply_be(mtimecmp_q, bram_wrdata_i, bram_we_i);
        end
        if (wr && sel_msip && bram_we_i[0]) begin
            msip_d = bram_wrdata_i[0];
        end

        // Reads observe the pre-update register value.
        if (bram_en_i) begin
            rdata_d = rd_val;
        end

        irq_d = (mtime_d >= mtimecmp_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
            msip_q     <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bram_rddata_o = rdata_q;
    assign time_o        = mtime_q;
    assign timer_irq_o   = irq_q;
    assign ipi_o         = msip_q;

endmodule
